// File: rtl/serial_word_collector_if.sv
// Serial-bit in / parallel-word out bus of serial_word_collector.
// Source-and-consumer side is the master; the collector is the slave.
interface serial_word_collector_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic             bit_in;
    logic             bit_valid;
    logic             shift;
    logic             clear;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overflow;
    logic [CW-1:0]    bit_count;

    modport master (
        output bit_in, bit_valid, shift, clear, word_ready,
        input  word_out, word_valid, overflow, bit_count
    );

    modport slave (
        input  bit_in, bit_valid, shift, clear, word_ready,
        output word_out, word_valid, overflow, bit_count
    );
endinterface

// File: rtl/serial_word_collector.sv
// Assembles WIDTH-bit words from a qualified serial stream (MSB- or LSB-first)
// into a one-entry valid/ready output buffer with a sticky drop flag.
module serial_word_collector #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_word_collector_if.slave bus
);
    localparam int unsigned      CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, COLLECT} col_state_t;
    typedef enum logic {EMPTY, FULL}   buf_state_t;

    col_state_t       col_q, col_d;
    buf_state_t       buf_q, buf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ord_q, ord_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             ovf_q, ovf_d;

    logic             ins_ord;
    logic [WIDTH-1:0] acc_ins;
    logic             complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= IDLE;
            buf_q  <= EMPTY;
            acc_q  <= '0;
            cnt_q  <= '0;
            ord_q  <= 1'b0;
            word_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            buf_q  <= buf_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            ord_q  <= ord_d;
            word_q <= word_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        col_d    = col_q;
        buf_d    = buf_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ord_d    = ord_q;
        word_d   = word_q;
        ovf_d    = ovf_q;
        complete = 1'b0;

        // Bit order is sampled from shift only on the first bit of a word.
        ins_ord = (col_q == IDLE) ? bus.shift : ord_q;
        acc_ins = ins_ord ? {bus.bit_in, acc_q[WIDTH-1:1]}
                          : {acc_q[WIDTH-2:0], bus.bit_in};

        if (bus.clear) begin
            col_d = IDLE;
            cnt_d = '0;
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (bus.bit_valid) begin
            acc_d = acc_ins;
            ord_d = ins_ord;
            if (cnt_q == LAST_CNT) begin
                complete = 1'b1;
                cnt_d    = '0;
                col_d    = IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
                col_d = COLLECT;
            end
        end

        // A drain on the completing edge frees the slot for the new word.
        if (complete) begin
            if (buf_q == EMPTY || bus.word_ready) begin
                word_d = acc_ins;
                buf_d  = FULL;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (buf_q == FULL && bus.word_ready) begin
            buf_d = EMPTY;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (buf_q == FULL);
    assign bus.overflow   = ovf_q;
    assign bus.bit_count  = cnt_q;
endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: directed test-plan steps
// followed by random traffic, all checked against a queue-based model.
module tb_serial_word_collector;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W) + 1;

    logic clk;
    logic rst_n;

    serial_word_collector_if #(.WIDTH(W)) bus ();

    serial_word_collector #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: collected bits of the current word plus the buffer.
    logic         m_bits[$];
    logic         m_ord;
    logic [W-1:0] m_word;
    logic         m_valid;
    logic         m_ovf;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_ord   = 1'b0;
        m_word  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge();
        logic         done;
        logic [W-1:0] w;
        done = 1'b0;
        w    = '0;
        if (bus.clear) begin
            m_bits.delete();
            m_ovf = 1'b0;
        end else if (bus.bit_valid) begin
            if (m_bits.size() == 0) m_ord = bus.shift;
            m_bits.push_back(bus.bit_in);
            if (m_bits.size() == W) begin
                for (int i = 0; i < int'(W); i++) begin
                    if (m_ord) w[i] = m_bits[i];
                    else       w[int'(W) - 1 - i] = m_bits[i];
                end
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || bus.word_ready) begin
                m_word  = w;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && bus.word_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".word_out"},   16'(bus.word_out),   16'(m_word));
        check({tag, ".word_valid"}, 16'(bus.word_valid), 16'(m_valid));
        check({tag, ".overflow"},   16'(bus.overflow),   16'(m_ovf));
        check({tag, ".bit_count"},  16'(bus.bit_count),  16'(m_bits.size()));
    endtask

    // One clock: inputs already applied, update model at the edge, sample 1ns later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic v, input logic b, input logic sh,
                         input logic rdy, input logic clr, input string tag);
        bus.bit_valid  = v;
        bus.bit_in     = b;
        bus.shift      = sh;
        bus.word_ready = rdy;
        bus.clear      = clr;
        tick(tag);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic sh, input string tag);
        for (int i = 0; i < int'(W); i++)
            drive(1'b1, sh ? w[i] : w[int'(W) - 1 - i], sh, 1'b0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tag);
        bus.word_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] seq;

        rst_n          = 1'b0;
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.shift      = 1'b0;
        bus.clear      = 1'b0;
        bus.word_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        #4 rst_n = 1'b1;

        // MSB first: 1,0,1,1 -> 1011, bit_count 1,2,3,0
        seq = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[3 - i], 1'b0, 1'b0, 1'b0, "msb");
            check("msb.cnt_step", 16'(bus.bit_count), 16'((i + 1) % 4));
        end
        check("msb.word", 16'(bus.word_out), 16'h000b);
        check("msb.valid", 16'(bus.word_valid), 16'h0001);
        drain("msb.drain");

        // LSB first: 1,0,1,1 -> 1101
        seq = 4'b1011;
        for (int i = 0; i < 4; i++)
            drive(1'b1, seq[3 - i], 1'b1, 1'b0, 1'b0, "lsb");
        check("lsb.word", 16'(bus.word_out), 16'h000d);
        drain("lsb.drain");

        // Backpressure: A kept, B dropped
        send_word(4'hA, 1'b0, "bp.a");
        send_word(4'h5, 1'b0, "bp.b");
        check("bp.ovf", 16'(bus.overflow), 16'h0001);
        check("bp.word", 16'(bus.word_out), 16'h000a);
        drain("bp.drain");
        check("bp.valid_after", 16'(bus.word_valid), 16'h0000);
        check("bp.ovf_sticky", 16'(bus.overflow), 16'h0001);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bp.clear");
        check("bp.ovf_cleared", 16'(bus.overflow), 16'h0000);

        // Drain coincident with completion
        send_word(4'h3, 1'b0, "sim.a");
        seq = 4'hC;
        for (int i = 0; i < 4; i++)
            drive(1'b1, seq[3 - i], 1'b0, (i == 3), 1'b0, "sim.b");
        bus.word_ready = 1'b0;
        check("sim.word", 16'(bus.word_out), 16'h000c);
        check("sim.valid", 16'(bus.word_valid), 16'h0001);
        check("sim.ovf", 16'(bus.overflow), 16'h0000);
        drain("sim.drain");

        // shift toggled mid-word stays MSB first
        seq = 4'b1100;
        for (int i = 0; i < 4; i++)
            drive(1'b1, seq[3 - i], (i >= 2), 1'b0, 1'b0, "tog");
        check("tog.word", 16'(bus.word_out), 16'h000c);
        drain("tog.drain");

        // clear with bit_valid after 3 bits, then a fresh word
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "clr.pre");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "clr.edge");
        check("clr.cnt", 16'(bus.bit_count), 16'h0000);
        check("clr.valid", 16'(bus.word_valid), 16'h0000);
        send_word(4'h6, 1'b0, "clr.fresh");
        check("clr.word", 16'(bus.word_out), 16'h0006);

        // Async reset mid-word with a buffered word
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst.pre");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst.pre");
        bus.bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.word", 16'(bus.word_out), 16'h0000);
        check("rst.valid", 16'(bus.word_valid), 16'h0000);
        check("rst.ovf", 16'(bus.overflow), 16'h0000);
        check("rst.cnt", 16'(bus.bit_count), 16'h0000);
        #2 rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Downstream consumer of the bidirectional shift register's serial output. Assembles WIDTH-bit parallel words from a qualified serial bit stream in either bit order, selected by the same `shift` direction signal that drives the register. Holds each completed word in a one-entry output buffer with a valid/ready handshake and flags words lost to backpressure.

## Interface
- `WIDTH`, default 4: word width in bits; legal range is 2 to 16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  serial data bit, taken from the register's `Q`.
- `bit_valid`  in  1  `bit_in` is accepted on this edge.
- `shift`  in  1  bit order of the incoming word.
  - 1: LSB arrives first.
  - 0: MSB arrives first.
- `clear`  in  1  synchronous abort of the partial word; also clears `overflow`.
- `word_out`  out  WIDTH  completed word; stable while `word_valid`=1.
- `word_valid`  out  1  output buffer holds an unconsumed word.
- `word_ready`  in  1  consumer accepts `word_out` on this edge when `word_valid`=1.
- `overflow`  out  1  sticky flag: a completed word was dropped.
- `bit_count`  out  log2(WIDTH)+1  number of bits collected into the current partial word.

## Operation
- Accumulator state:
  - Internal accumulator `acc[WIDTH-1:0]`.
  - Counter `cnt`, range 0..WIDTH-1, driven out as `bit_count`.
  - Latched order bit `ord`.
- Collector FSM has two states: IDLE (`cnt`=0) and COLLECT (`cnt`>0).
  - IDLE + `bit_valid` -> `ord` <= `shift`; the bit is inserted; `cnt` <= 1; go to COLLECT.
  - COLLECT: `shift` is ignored and `ord` stays fixed until the word completes or is cleared.
- Bit insertion, using `ord`, or `shift` on the first bit of a word:
  - `ord`=0 (MSB first): `acc` <= {`acc[WIDTH-2:0]`, `bit_in`}.
  - `ord`=1 (LSB first): `acc` <= {`bit_in`, `acc[WIDTH-1:1]`}.
- Word completion: `bit_valid` while `cnt`=WIDTH-1.
  - The completed word is the post-insertion value of `acc`.
  - `cnt` wraps to 0; the FSM returns to IDLE.
- Output buffer has two states, EMPTY and FULL, visible as `word_valid`.
  - On completion, if EMPTY, or FULL with `word_ready`=1 on the same edge: `word_out` <= completed word; the buffer ends FULL.
  - On completion, if FULL with `word_ready`=0: the completed word is discarded; `word_out` is unchanged; `overflow` <= 1.
  - FULL and `word_ready`=1 with no completion -> EMPTY; `word_out` keeps its last value.
- `clear`:
  - Effect: `cnt` <= 0, `acc` <= 0, `overflow` <= 0.
  - The output buffer is untouched.
  - `clear` has priority over `bit_valid` on the same edge; that bit is discarded.
- `word_ready` while EMPTY: no effect.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - Outputs: `word_out`=0, `word_valid`=0, `overflow`=0, `bit_count`=0.
  - Internal: `acc`=0, `ord`=0.
- Reset asserted mid-word discards the partial word and any buffered word. Deassertion is synchronised by the system, and the first accepted bit is on the first rising edge after deassertion.
- One bit is accepted per clock with `bit_valid`=1. Gaps of any length between bits are legal; `acc` and `cnt` hold during gaps.
- Latency: `word_valid` rises on the same edge that accepts the final bit, so it is visible in the following cycle.
- Throughput: one word every WIDTH cycles is sustained only if `word_ready` is asserted at least once between completions.
- `overflow` rises on the edge of the dropped completion. It stays high until `clear` or reset.

## Test plan
- MSB first, WIDTH=4: `shift`=0, bits 1,0,1,1 on consecutive cycles, `word_ready`=0.
  - Required: `word_out`=4'b1011 and `word_valid`=1 one cycle after the 4th bit; `bit_count` steps 1,2,3,0.
- LSB first: `shift`=1, bits 1,0,1,1.
  - Required: `word_out`=4'b1101.
- Backpressure, `word_ready`=0 throughout: complete word A=4'hA, then word B=4'h5.
  - Required: `overflow`=1; `word_out` stays 4'hA.
  - Then `word_ready`=1 for one cycle. Required: `word_valid`=0 and `overflow` stays 1.
- Simultaneous drain and completion: with A=4'h3 buffered, assert `word_ready`=1 on the edge that accepts the last bit of B=4'hC.
  - Required: `word_out`=4'hC, `word_valid` stays 1, `overflow`=0.
- Mid-word control changes:
  - Toggle `shift` after the 2nd bit of an MSB-first word. Required: the word is still assembled MSB-first.
  - Assert `clear` together with `bit_valid` after 3 bits. Required: `bit_count`=0 and the next 4 bits form a fresh word.
- Reset mid-operation: pull `rst_n` low asynchronously after 2 bits, with a word buffered.
  - Required: all outputs 0 immediately, before the next clock edge.
